// File: rtl/report_collector_if.sv
// Read-side handshake between the report collector and the monitor readout logic.
// The collector drives a first-word fall-through head record; the reader answers with rd_ready.
interface report_collector_if #(
  parameter int REPORT_W = 52,
  parameter int STAMP_W  = 32
);
  logic                rd_valid;
  logic                rd_ready;
  logic [REPORT_W-1:0] rd_report;
  logic [STAMP_W-1:0]  rd_stamp;

  modport master (output rd_valid, rd_report, rd_stamp, input rd_ready);
  modport slave  (input rd_valid, rd_report, rd_stamp, output rd_ready);
endinterface

// File: rtl/report_collector.sv
// Timestamps every non-zero per-symbol report vector from a cluster stage and queues it
// in a fall-through FIFO for the monitor reader; drops on overflow are flagged and counted.
module report_collector #(
  parameter int REPORT_W = 52,
  parameter int DEPTH    = 16,
  parameter int STAMP_W  = 32,
  parameter int DROP_W   = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     run,
  input  logic                     sym_reset,
  input  logic [REPORT_W-1:0]      report_in,
  report_collector_if.master       rd,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic [DROP_W-1:0]        drop_count
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int EW = STAMP_W + REPORT_W;

  logic [EW-1:0]      mem [DEPTH];
  logic [AW-1:0]      wr_ptr_reg, wr_ptr_next;
  logic [AW-1:0]      rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]      level_reg, level_next;
  logic [STAMP_W-1:0] stamp_reg, stamp_next;
  logic               overflow_reg, overflow_next;
  logic [DROP_W-1:0]  drop_count_reg, drop_count_next;

  logic          push_req, full, push, pop, drop;
  logic [EW-1:0] head;

  // sym_reset masks both sides so a flush cycle neither stores nor retires anything
  assign push_req = run & ~sym_reset & (|report_in);
  assign full     = (level_reg == LW'(DEPTH));
  assign pop      = (level_reg != '0) & rd.rd_ready & ~sym_reset;
  // When full, a same-cycle pop frees the head slot the new record lands in
  assign push     = push_req & (~full | pop);
  assign drop     = push_req & full & ~pop;

  always_comb begin
    wr_ptr_next     = wr_ptr_reg;
    rd_ptr_next     = rd_ptr_reg;
    level_next      = level_reg;
    stamp_next      = stamp_reg;
    overflow_next   = overflow_reg;
    drop_count_next = drop_count_reg;
    if (sym_reset) begin
      wr_ptr_next     = '0;
      rd_ptr_next     = '0;
      level_next      = '0;
      stamp_next      = '0;
      overflow_next   = 1'b0;
      drop_count_next = '0;
    end else begin
      if (run)
        stamp_next = stamp_reg + 1'b1;
      if (push)
        wr_ptr_next = wr_ptr_reg + 1'b1;
      if (pop)
        rd_ptr_next = rd_ptr_reg + 1'b1;
      if (push && !pop)
        level_next = level_reg + 1'b1;
      else if (pop && !push)
        level_next = level_reg - 1'b1;
      if (drop) begin
        overflow_next = 1'b1;
        if (drop_count_reg != {DROP_W{1'b1}})
          drop_count_next = drop_count_reg + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      stamp_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= '0;
    end else begin
      wr_ptr_reg     <= wr_ptr_next;
      rd_ptr_reg     <= rd_ptr_next;
      level_reg      <= level_next;
      stamp_reg      <= stamp_next;
      overflow_reg   <= overflow_next;
      drop_count_reg <= drop_count_next;
    end
  end

  // Storage carries no reset; stale entries are hidden by the level-based output gating
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr_reg] <= {stamp_reg, report_in};
  end

  assign head         = mem[rd_ptr_reg];
  assign rd.rd_valid  = (level_reg != '0);
  assign rd.rd_report = rd.rd_valid ? head[REPORT_W-1:0] : '0;
  assign rd.rd_stamp  = rd.rd_valid ? head[EW-1:REPORT_W] : '0;
  assign level        = level_reg;
  assign overflow     = overflow_reg;
  assign drop_count   = drop_count_reg;
endmodule

// File: doc/report_collector.md
Name: report_collector

Overview:
- Receiving end of the automata stage report outputs. One instance sits after a cluster stage and gathers that cluster's per-cycle report bits (52 for a stage).
- Each non-zero report vector is timestamped with the symbol-cycle count and buffered in a FIFO.
- Records are handed to the monitor readout logic over a valid/ready interface, so report hits are never lost silently between pipeline stages and the host-side reader.

Parameters:
- REPORT_W, 52, width of the report vector (one bit per automaton report state).
- DEPTH, 16, FIFO entries; power of two, >= 2.
- STAMP_W, 32, width of the symbol-cycle timestamp.
- DROP_W, 16, width of the saturating dropped-record counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- run  in  1  symbol-cycle qualifier, same signal that drives the stage; high means report_in is valid this cycle.
- sym_reset  in  1  synchronous, active-high automata reset from the stage (out_reset); flushes the collector.
- report_in  in  REPORT_W  report bits from the stage, sampled when run=1.
- rd_valid  out  1  head record available.
- rd_ready  in  1  reader accepts head record.
- rd_report  out  REPORT_W  head record report vector.
- rd_stamp  out  STAMP_W  head record timestamp.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow  out  1  sticky: at least one record dropped since last flush.
- drop_count  out  DROP_W  number of dropped records, saturating at all-ones.

Behaviour:
- Reset, asynchronous on reset_n low: stamp counter = 0, FIFO empty, level = 0, rd_valid = 0, overflow = 0, drop_count = 0. rd_report and rd_stamp read as 0 while empty.
- Stamp counter:
  - Increments by 1 on every clk edge with run=1 and sym_reset=0.
  - Holds when run=0.
  - Wraps from 2^STAMP_W-1 to 0 with no flag.
- Push condition: run=1, sym_reset=0, report_in != 0. The pushed record is {stamp value before this cycle's increment, report_in}. The first symbol after reset therefore carries stamp 0.
- report_in = 0 never creates a record. report_in is ignored when run=0.
- FIFO:
  - First-word fall-through. rd_valid = (level != 0).
  - rd_report and rd_stamp show the head entry combinationally from the registered storage and pointers.
  - Pop occurs when rd_valid & rd_ready. rd_ready while empty has no effect.
  - rd_report and rd_stamp must stay stable while rd_valid=1 and rd_ready=0.
  - Read and write pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
  - A record pushed into an empty FIFO is visible at the outputs one cycle after the push edge. Latency from report_in to rd_valid = 1 clk.
- Simultaneous push and pop:
  - Not full: both occur, level unchanged.
  - Full (level = DEPTH) with pop the same cycle: push accepted, level stays at DEPTH, nothing dropped.
- Push while full with no pop: record discarded; overflow set to 1; drop_count += 1, saturating.
- sym_reset=1 (synchronous, takes priority over everything):
  - Pointers cleared, level = 0, stamp = 0, overflow = 0, drop_count = 0.
  - report_in and any pop that cycle are ignored.
  - rd_valid is 0 in the following cycle.
- level: updated on the same edge as push and pop.
- Asynchronous reset mid-transfer: all records are discarded and there is no partial output. The reader must tolerate rd_valid dropping.

Test Plan:
- Basic capture: reset, run=1 for 5 cycles with report_in = 0,0,0x1,0,0x8000_0000_0000 (bit 47), rd_ready=0 → level=2. Head = {stamp 2, 0x1}, then {stamp 4, bit47}. overflow=0.
- Back-pressure and stability: push 3 records, hold rd_ready=0 for 10 cycles → rd_report and rd_stamp constant. Then rd_ready=1 → 3 pops on consecutive cycles, rd_valid=0 afterwards, level=0.
- Overflow: DEPTH=16, rd_ready=0, 20 consecutive non-zero reports → level=16, overflow=1, drop_count=4. FIFO holds stamps 0..15 in order.
- Full with simultaneous pop: fill to 16, then push with rd_ready=1 in the same cycle → level stays 16, drop_count unchanged, tail = new record.
- Flush: with 7 records queued and overflow=1, pulse sym_reset for 1 cycle while report_in != 0 and run=1 → next cycle rd_valid=0, level=0, overflow=0, drop_count=0. The next reported symbol has stamp 0.
- Wrap: STAMP_W=4, 18 run cycles with report on cycles 15 and 16 → stamps 15 then 0. Push/pop across pointer wrap (interleave 40 push/pop) → data order matches a scoreboard.
